tcdm_bank_responder: RTL and testbench

TCDM_BANK_RESPONDER -- requirements
Module: tcdm_bank_responder

---
 rtl/tcdm_responder_package.sv | 7 +
 rtl/tcdm_rr_arbiter.sv | 29 ++
 rtl/tcdm_bank_responder.sv | 59 +++++
 tb/tb_tcdm_bank_responder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/tcdm_responder_package.sv
// tcdm_responder_package: shared widths and wen encoding for the TCDM bank responder
package tcdm_responder_package;
  localparam int DW = 32;
  localparam int BEW = 4;
  localparam logic WEN_READ = 1'b1;
  localparam logic WEN_WRITE = 1'b0;
endpackage

// File: rtl/tcdm_rr_arbiter.sv
// tcdm_rr_arbiter: round-robin one-hot grant, search starts after last granted port
module tcdm_rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr, nxt;
  always_comb begin
    gnt = '0;
    nxt = ptr;
    // descending offsets so the closest requester after ptr wins last
    for (int i = N; i >= 1; i--) begin
      if (en && req[(int'(ptr) + i) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + i) % N] = 1'b1;
        nxt = PW'((int'(ptr) + i) % N);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= PW'(N - 1);
    else if (|gnt) ptr <= nxt;
  end
endmodule

// File: rtl/tcdm_bank_responder.sv
// tcdm_bank_responder: single-port byte-writable bank serving NB_PORTS TCDM initiators round-robin
module tcdm_bank_responder
  import tcdm_responder_package::*;
#(
  parameter int NB_PORTS = 3,
  parameter int MEM_WORDS = 1024,
  parameter int WORD_AW = $clog2(MEM_WORDS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic [NB_PORTS-1:0]           tcdm_req,
  output logic [NB_PORTS-1:0]           tcdm_gnt,
  input  logic [NB_PORTS-1:0][31:0]     tcdm_add,
  input  logic [NB_PORTS-1:0]           tcdm_wen,
  input  logic [NB_PORTS-1:0][BEW-1:0]  tcdm_be,
  input  logic [NB_PORTS-1:0][DW-1:0]   tcdm_data,
  output logic [NB_PORTS-1:0][DW-1:0]   tcdm_r_data,
  output logic [NB_PORTS-1:0]           tcdm_r_valid
);
  localparam int PW = NB_PORTS > 1 ? $clog2(NB_PORTS) : 1;
  logic [DW-1:0] mem [MEM_WORDS];
  logic [PW-1:0] sel, rsp_port;
  logic rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [WORD_AW-1:0] widx;
  logic any_gnt;
  tcdm_rr_arbiter #(.N(NB_PORTS)) u_arb (
    .clk(clk),
    .rst(rst),
    .en (!stall && !rst),
    .req(tcdm_req),
    .gnt(tcdm_gnt)
  );
  always_comb begin
    sel = '0;
    for (int p = 0; p < NB_PORTS; p++) if (tcdm_gnt[p]) sel = PW'(p);
  end
  assign any_gnt = |tcdm_gnt;
  assign widx = tcdm_add[sel][WORD_AW+1:2];
  always_ff @(posedge clk) begin
    for (int b = 0; b < BEW; b++)
      if (any_gnt && tcdm_wen[sel] == WEN_WRITE && tcdm_be[sel][b]) mem[widx][8*b +: 8] <= tcdm_data[sel][8*b +: 8];
  end
  always_ff @(posedge clk) begin
    rsp_port <= sel;
    rsp_data <= tcdm_wen[sel] == WEN_READ ? mem[widx] : '0;
    rsp_valid <= rst ? 1'b0 : any_gnt;
  end
  // outputs forced low during reset so a response in flight never surfaces
  always_comb begin
    tcdm_r_valid = '0;
    tcdm_r_data = '0;
    for (int p = 0; p < NB_PORTS; p++) begin
      tcdm_r_valid[p] = !rst && rsp_valid && rsp_port == PW'(p);
      tcdm_r_data[p] = tcdm_r_valid[p] ? rsp_data : '0;
    end
  end
endmodule

// File: tb/tb_tcdm_bank_responder.sv
// tb_tcdm_bank_responder: directed vectors against a behavioural bank model plus literal checks
module tb_tcdm_bank_responder;
  logic clk = 0, rst = 1, stall = 0;
  logic [2:0] tcdm_req = '0, tcdm_gnt, tcdm_wen = '1, tcdm_r_valid;
  logic [2:0][31:0] tcdm_add = '0, tcdm_data = '0, tcdm_r_data;
  logic [2:0][3:0] tcdm_be = '0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] mem_m [1024];
  int ptr = 2, pend = -1;
  logic [31:0] pend_data = '0;
  tcdm_bank_responder dut (
    .clk(clk), .rst(rst), .stall(stall), .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt),
    .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen), .tcdm_be(tcdm_be), .tcdm_data(tcdm_data),
    .tcdm_r_data(tcdm_r_data), .tcdm_r_valid(tcdm_r_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int model_sel();
    if (rst || stall) return -1;
    for (int k = 1; k <= 3; k++) if (tcdm_req[(ptr + k) % 3]) return (ptr + k) % 3;
    return -1;
  endfunction
  always @(posedge clk) begin
    int g, w;
    g = model_sel();
    if (rst) begin
      ptr = 2;
      pend = -1;
    end else if (g >= 0) begin
      w = int'(tcdm_add[g] / 4) % 1024;
      if (tcdm_wen[g]) pend_data = mem_m[w];
      else begin
        for (int b = 0; b < 4; b++) if (tcdm_be[g][b]) mem_m[w][8*b +: 8] = tcdm_data[g][8*b +: 8];
        pend_data = 0;
      end
      pend = g;
      ptr = g;
    end else pend = -1;
  end
  always @(negedge clk) begin
    logic [2:0] eg, erv;
    logic [2:0][31:0] erd;
    int g;
    g = model_sel();
    eg = '0;
    erv = '0;
    erd = '0;
    if (g >= 0) eg[g] = 1'b1;
    if (!rst && pend >= 0) begin
      erv[pend] = 1'b1;
      erd[pend] = pend_data;
    end
    chk("gnt", 96'(tcdm_gnt), 96'(eg));
    chk("r_valid", 96'(tcdm_r_valid), 96'(erv));
    chk("r_data", tcdm_r_data, erd);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic acc(input int p, input logic wen, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    tcdm_req[p] = 1'b1;
    tcdm_wen[p] = wen;
    tcdm_add[p] = a;
    tcdm_be[p] = be;
    tcdm_data[p] = d;
  endtask
  initial begin
    cyc();
    cyc();
    chk("rst_gnt", 96'(tcdm_gnt), 96'h0);
    chk("rst_rvalid", 96'(tcdm_r_valid), 96'h0);
    rst = 0;
    acc(0, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF);
    #1 chk("b34_gnt0", 96'(tcdm_gnt), 96'h1);
    cyc();
    tcdm_req = '0;
    acc(1, 1'b1, 32'h10, 4'h0, 32'h0);
    #1 chk("b34_gnt1", 96'(tcdm_gnt), 96'h2);
    cyc();
    tcdm_req = '0;
    chk("b34_rvalid", 96'(tcdm_r_valid), 96'h2);
    chk("b34_rdata", 96'(tcdm_r_data[1]), 96'hDEADBEEF);
    acc(0, 1'b0, 32'h20, 4'hF, 32'h11223344);
    cyc();
    acc(0, 1'b0, 32'h20, 4'b0101, 32'hAABBCCDD);
    cyc();
    tcdm_req = '0;
    acc(2, 1'b1, 32'h20, 4'h0, 32'h0);
    cyc();
    tcdm_req = '0;
    chk("b35_merge", 96'(tcdm_r_data[2]), 96'h11BB33DD);
    for (int p = 0; p < 3; p++) acc(p, 1'b1, 32'h10, 4'h0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      #1 chk("b36_order", 96'(tcdm_gnt), 96'(3'b001 << (k % 3)));
      cyc();
      chk("b36_rvalid_onehot", 96'($countones(tcdm_r_valid)), 96'd1);
    end
    tcdm_req = '0;
    stall = 1;
    acc(2, 1'b1, 32'h20, 4'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("b37_stalled", 96'(tcdm_gnt), 96'h0);
      cyc();
    end
    stall = 0;
    #1 chk("b37_gnt2", 96'(tcdm_gnt), 96'h4);
    cyc();
    tcdm_req = '0;
    chk("b37_rvalid", 96'(tcdm_r_valid), 96'h4);
    acc(0, 1'b0, 32'h1000, 4'hF, 32'h5);
    cyc();
    tcdm_req = '0;
    acc(1, 1'b1, 32'h0, 4'h0, 32'h0);
    cyc();
    acc(1, 1'b1, 32'h3, 4'h0, 32'h0);
    chk("b38_alias", 96'(tcdm_r_data[1]), 96'h5);
    cyc();
    tcdm_req = '0;
    chk("b38_lowbits", 96'(tcdm_r_data[1]), 96'h5);
    for (int w = 0; w < 8; w++) begin
      acc(0, 1'b0, 32'(w * 4), 4'hF, $urandom);
      cyc();
    end
    tcdm_req = '0;
    for (int k = 0; k < 60; k++) begin
      stall = ($urandom_range(0, 5) == 0);
      for (int p = 0; p < 3; p++) begin
        tcdm_req[p] = $urandom_range(0, 1) == 1;
        tcdm_wen[p] = $urandom_range(0, 1) == 1;
        tcdm_add[p] = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3) + ($urandom_range(0, 1) << 12));
        tcdm_be[p] = 4'($urandom);
        tcdm_data[p] = $urandom;
      end
      cyc();
    end
    stall = 0;
    tcdm_req = '0;
    acc(1, 1'b1, 32'h0, 4'h0, 32'h0);
    cyc();
    tcdm_req = '0;
    rst = 1;
    #1 chk("b39_rst_rvalid", 96'(tcdm_r_valid), 96'h0);
    cyc();
    rst = 0;
    chk("b39_after_rvalid", 96'(tcdm_r_valid), 96'h0);
    tcdm_req = 3'b111;
    tcdm_wen = 3'b111;
    #1 chk("b39_first_gnt", 96'(tcdm_gnt), 96'h1);
    cyc();
    tcdm_req = '0;
    cyc();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
